prf_multiport: RTL and testbench
================================

# prf_multiport

Parametrised multi-ported physical register file for the out-of-order core. It replaces the fixed five-writer, per-unit register file.
- Any number of writeback ports and read ports.
- Registered reads with same-cycle write bypass.
- A per-register ready (busy) table for the reservation stations, set on writeback, cleared on rename allocation, and bulk-set on pipeline flush.

It sits between the CDB/writeback stage and the reservation stations/functional-unit operand fetch.

## Interface
Parameters:
- PHYS_REG_BITS, 6, physical register index width; depth = 2**PHYS_REG_BITS
- NUM_WR, 5, writeback ports (add, mul, div, mem, br)
- NUM_RD, 10, operand read ports (two per functional unit)
- NUM_CHK, 4, ready-query ports used by dispatch

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  NUM_WR  per-port write enable
- wr_preg  in  NUM_WR x PHYS_REG_BITS  destination physical register
- wr_arch_zero  in  NUM_WR  destination architectural register is x0; value written is 0
- wr_data  in  NUM_WR x 32  writeback value
- rd_en  in  NUM_RD  per-port read request
- rd_preg  in  NUM_RD x PHYS_REG_BITS  source physical register
- rd_data  out  NUM_RD x 32  registered read data
- alloc_en  in  1  rename allocated a new destination
- alloc_preg  in  PHYS_REG_BITS  physical register just allocated
- flush  in  1  pipeline flush
- chk_preg  in  NUM_CHK x PHYS_REG_BITS  ready query index
- chk_ready  out  NUM_CHK  combinational ready result
- wr_conflict  out  1  sticky error flag

## Operation
- Register p0 is hardwired:
  - It always reads 0 and is always ready.
  - Writes to it are dropped.
  - Allocations of it are ignored.
- Write, port i with wr_en[i]=1 and wr_preg[i]!=0:
  - data[wr_preg[i]] gets wr_arch_zero[i] ? 0 : wr_data[i].
  - ready[wr_preg[i]] is set to 1.
- Multiple writers to the same preg in one cycle:
  - The lowest port index wins.
  - wr_conflict is set and held until reset.
- Read, port j with rd_en[j]=1:
  - rd_data[j] loads the value of rd_preg[j] at the next edge.
  - If a write to that preg is happening in the same cycle, the write data is returned (bypass), with the lowest writer winning.
  - If rd_en[j]=0, rd_data[j] holds its previous value.
- Allocation: alloc_en with alloc_preg!=0 clears ready[alloc_preg].
  - Allocation and a write to the same preg in the same cycle: alloc wins (ready=0), the data is still written, and wr_conflict is set.
- Flush: sets all ready bits to 1 at the next edge and takes priority over alloc in the same cycle. The data array is untouched.
- chk_ready[k] = ready[chk_preg[k]] OR (a same-cycle write to chk_preg[k]). This is the wakeup bypass. A same-cycle alloc does not affect chk_ready until the next cycle.

## Timing
- Reset (rst_n low, asynchronous):
  - All data = 0.
  - All ready = 1.
  - All rd_data = 0.
  - wr_conflict = 0.
  - This takes effect immediately, without waiting for clk.
- Reset deasserted mid-operation: the first edge after release behaves as a normal cycle. No requests are remembered across reset.
- Write latency: data is visible in the array at the edge after wr_en.
- Read latency: 1 cycle. A request in cycle T gives rd_data valid in cycle T+1, including the bypass case.
- Write in T followed by read request in T+1: array value, returned at T+2.
- chk_ready: 0 cycles (combinational), reflecting the current state plus same-cycle writes.
- No handshake or backpressure: every port is accepted every cycle.

## Structure
- Shared package (rv32i_types):
  - PHYS_REG_BITS
  - typedef preg_t (logic [PHYS_REG_BITS-1:0])
  - NUM_WR_PORTS
  - NUM_RD_PORTS
- Sub-module prf_read_port, instantiated NUM_RD times, contains:
  - the write-bypass priority mux over NUM_WR writers,
  - the p0 zeroing,
  - the hold-capable output register.
- The top level holds:
  - the data array,
  - the ready bit-vector,
  - the write priority/conflict logic,
  - the check ports.

## Test plan
- Reset then read all pregs: every rd_data = 0 one cycle after rd_en, and chk_ready = 1 for all pregs.
- Writes and read the same cycle:
  - Write port 0 sets p5=0xDEADBEEF while read port 3 reads p5 in the same cycle -> rd_data[3]=0xDEADBEEF next cycle.
  - Port 3 reads p5 again 2 cycles later -> same value.
  - Write with wr_arch_zero=1 to p7 -> p7 reads 0.
- Allocate, write back, flush:
  - alloc p9 -> chk_ready=0 next cycle.
  - Write p9 -> chk_ready=1 in the same cycle.
  - alloc p9 again, then flush, then chk p9 -> 1.
- Write conflict:
  - Ports 1 and 4 both write p12 (0x11, 0x44) -> p12 reads 0x11 and wr_conflict=1.
  - wr_conflict stays 1 until rst_n is asserted.
- p0 protection: write 0xFFFFFFFF to p0 -> reads 0. alloc p0 -> chk_ready stays 1.
- Async reset mid-stream:
  - Pull rst_n low between edges after writing p20 -> rd_data clears immediately.
  - After release, p20 reads 0 and ready is all ones.

Source files
------------

// File: rtl/prf_multiport_pkg.sv
// Shared types and sizing constants for the physical register file slice.
// Provides the physical register index width, the preg_t index type, the
// datapath width and the default port counts used by prf_multiport and its
// read-port sub-module.
package rv32i_types;

  localparam int PHYS_REG_BITS = 6;
  localparam int XLEN          = 32;
  localparam int NUM_WR_PORTS  = 5;
  localparam int NUM_RD_PORTS  = 10;
  localparam int NUM_CHK_PORTS = 4;

  typedef logic [PHYS_REG_BITS-1:0] preg_t;

endpackage

// File: rtl/prf_read_port.sv
// One registered operand read port of the physical register file.
// The next value is the array entry for rd_preg_i, overridden by any
// same-cycle writer to that register (lowest writer index wins), and forced
// to zero for p0. The output register only loads when rd_en_i is high and
// otherwise holds its previous value.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   rd_en_i        read request
//   rd_preg_i      source physical register
//   arr_data_i     current array contents of rd_preg_i
//   wr_valid_i     per-writer effective write (enabled and not p0)
//   wr_preg_i      per-writer destination register
//   wr_value_i     per-writer value as it will be stored
//   rd_data_o      registered read data
module prf_read_port #(
  parameter int PREG_W = rv32i_types::PHYS_REG_BITS,
  parameter int N_WR   = rv32i_types::NUM_WR_PORTS,
  parameter int DATA_W = rv32i_types::XLEN
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rd_en_i,
  input  logic [PREG_W-1:0]           rd_preg_i,
  input  logic [DATA_W-1:0]           arr_data_i,
  input  logic [N_WR-1:0]             wr_valid_i,
  input  logic [N_WR-1:0][PREG_W-1:0] wr_preg_i,
  input  logic [N_WR-1:0][DATA_W-1:0] wr_value_i,
  output logic [DATA_W-1:0]           rd_data_o
);

  logic [DATA_W-1:0] rdData_d;
  logic [DATA_W-1:0] rdData_q;

  // Bypass mux: scan writers from highest to lowest index so the lowest
  // matching writer is the last assignment and therefore wins.
  always_comb begin
    rdData_d = arr_data_i;
    for (int i = N_WR - 1; i >= 0; i--) begin
      if (wr_valid_i[i] && (wr_preg_i[i] == rd_preg_i)) begin
        rdData_d = wr_value_i[i];
      end
    end
    if (rd_preg_i == '0) begin
      rdData_d = '0;
    end
  end

  // Output register loads only on a request and clears asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdData_q <= '0;
    end else if (rd_en_i) begin
      rdData_q <= rdData_d;
    end
  end

  assign rd_data_o = rdData_q;

endmodule

// File: rtl/prf_multiport.sv
// Parametrised multi-ported physical register file with a per-register ready
// table for the reservation stations.
// Ports:
//   clk_i, rst_ni     clock and asynchronous active-low reset
//   wr_en_i           per-writer enable
//   wr_preg_i         per-writer destination physical register
//   wr_arch_zero_i    per-writer "destination is x0" (stores zero)
//   wr_data_i         per-writer value
//   rd_en_i           per-reader request
//   rd_preg_i         per-reader source physical register
//   rd_data_o         per-reader registered data (1-cycle latency, bypassed)
//   alloc_en_i        rename allocated alloc_preg_i (clears its ready bit)
//   alloc_preg_i      allocated physical register
//   flush_i           sets every ready bit at the next edge
//   chk_preg_i        per-query register index
//   chk_ready_o       combinational ready, including same-cycle writeback
//   wr_conflict_o     sticky flag for colliding writers or alloc/write clash
module prf_multiport import rv32i_types::XLEN; #(
  parameter int PHYS_REG_BITS = rv32i_types::PHYS_REG_BITS,
  parameter int NUM_WR        = rv32i_types::NUM_WR_PORTS,
  parameter int NUM_RD        = rv32i_types::NUM_RD_PORTS,
  parameter int NUM_CHK       = rv32i_types::NUM_CHK_PORTS
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NUM_WR-1:0]                  wr_en_i,
  input  logic [NUM_WR-1:0][PHYS_REG_BITS-1:0] wr_preg_i,
  input  logic [NUM_WR-1:0]                  wr_arch_zero_i,
  input  logic [NUM_WR-1:0][XLEN-1:0]        wr_data_i,
  input  logic [NUM_RD-1:0]                  rd_en_i,
  input  logic [NUM_RD-1:0][PHYS_REG_BITS-1:0] rd_preg_i,
  output logic [NUM_RD-1:0][XLEN-1:0]        rd_data_o,
  input  logic                               alloc_en_i,
  input  logic [PHYS_REG_BITS-1:0]           alloc_preg_i,
  input  logic                               flush_i,
  input  logic [NUM_CHK-1:0][PHYS_REG_BITS-1:0] chk_preg_i,
  output logic [NUM_CHK-1:0]                 chk_ready_o,
  output logic                               wr_conflict_o
);

  localparam int DEPTH = 2 ** PHYS_REG_BITS;

  logic [DEPTH-1:0][XLEN-1:0] data_q;
  logic [DEPTH-1:0][XLEN-1:0] data_d;
  logic [DEPTH-1:0]           ready_q;
  logic [DEPTH-1:0]           ready_d;
  logic                       conflict_q;
  logic                       conflict_d;

  logic [NUM_WR-1:0]           wrValid;
  logic [NUM_WR-1:0][XLEN-1:0] wrValue;
  logic                        allocValid;

  // Writes to p0 are dropped everywhere, and x0 destinations store zero.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wrValid[i] = wr_en_i[i] && (wr_preg_i[i] != '0);
      wrValue[i] = wr_arch_zero_i[i] ? '0 : wr_data_i[i];
    end
    allocValid = alloc_en_i && (alloc_preg_i != '0);
  end

  // Array update: writers applied highest index first so the lowest index
  // lands last and wins a collision.
  always_comb begin
    data_d = data_q;
    for (int i = NUM_WR - 1; i >= 0; i--) begin
      if (wrValid[i]) begin
        data_d[wr_preg_i[i]] = wrValue[i];
      end
    end
  end

  // Ready table: writeback sets, allocation clears (overriding a same-cycle
  // writeback), and flush sets everything, overriding allocation.
  always_comb begin
    ready_d = ready_q;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wrValid[i]) begin
        ready_d[wr_preg_i[i]] = 1'b1;
      end
    end
    if (allocValid) begin
      ready_d[alloc_preg_i] = 1'b0;
    end
    if (flush_i) begin
      ready_d = '1;
    end
  end

  // Conflict detection: any pair of writers hitting the same register, or
  // an allocation of a register that is being written back this cycle.
  always_comb begin
    conflict_d = conflict_q;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wrValid[i] && wrValid[j] && (wr_preg_i[i] == wr_preg_i[j])) begin
          conflict_d = 1'b1;
        end
      end
      if (allocValid && wrValid[i] && (wr_preg_i[i] == alloc_preg_i)) begin
        conflict_d = 1'b1;
      end
    end
  end

  // State registers; reset leaves data zero and every register ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q     <= '0;
      ready_q    <= '1;
      conflict_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      ready_q    <= ready_d;
      conflict_q <= conflict_d;
    end
  end

  // Wakeup bypass: a register is ready if the table says so or it is being
  // written back right now. p0 is always set in the table.
  always_comb begin
    for (int k = 0; k < NUM_CHK; k++) begin
      chk_ready_o[k] = ready_q[chk_preg_i[k]];
      for (int i = 0; i < NUM_WR; i++) begin
        if (wrValid[i] && (wr_preg_i[i] == chk_preg_i[k])) begin
          chk_ready_o[k] = 1'b1;
        end
      end
    end
  end

  assign wr_conflict_o = conflict_q;

  for (genvar j = 0; j < NUM_RD; j++) begin : gen_rd
    prf_read_port #(
      .PREG_W (PHYS_REG_BITS),
      .N_WR   (NUM_WR),
      .DATA_W (XLEN)
    ) u_rd (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .rd_en_i    (rd_en_i[j]),
      .rd_preg_i  (rd_preg_i[j]),
      .arr_data_i (data_q[rd_preg_i[j]]),
      .wr_valid_i (wrValid),
      .wr_preg_i  (wr_preg_i),
      .wr_value_i (wrValue),
      .rd_data_o  (rd_data_o[j])
    );
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Directed testbench for prf_multiport: a table of single-cycle write/read
// vectors followed by hand-written sequences for ready tracking, flush,
// conflicts, p0 protection and asynchronous reset.
module tb_prf_multiport;

  localparam int PB  = 6;
  localparam int NWR = 5;
  localparam int NRD = 10;
  localparam int NCK = 4;

  logic                    clk;
  logic                    rstN;
  logic [NWR-1:0]          wrEn;
  logic [NWR-1:0][PB-1:0]  wrPreg;
  logic [NWR-1:0]          wrArchZero;
  logic [NWR-1:0][31:0]    wrData;
  logic [NRD-1:0]          rdEn;
  logic [NRD-1:0][PB-1:0]  rdPreg;
  logic [NRD-1:0][31:0]    rdData;
  logic                    allocEn;
  logic [PB-1:0]           allocPreg;
  logic                    flush;
  logic [NCK-1:0][PB-1:0]  chkPreg;
  logic [NCK-1:0]          chkReady;
  logic                    wrConflict;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wrOn;
    int          wrPort;
    logic [5:0]  wrReg;
    logic [31:0] wrVal;
    logic        archZero;
    int          rdPort;
    logic [5:0]  rdReg;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[10];

  prf_multiport #(
    .PHYS_REG_BITS (PB),
    .NUM_WR        (NWR),
    .NUM_RD        (NRD),
    .NUM_CHK       (NCK)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .wr_en_i        (wrEn),
    .wr_preg_i      (wrPreg),
    .wr_arch_zero_i (wrArchZero),
    .wr_data_i      (wrData),
    .rd_en_i        (rdEn),
    .rd_preg_i      (rdPreg),
    .rd_data_o      (rdData),
    .alloc_en_i     (allocEn),
    .alloc_preg_i   (allocPreg),
    .flush_i        (flush),
    .chk_preg_i     (chkPreg),
    .chk_ready_o    (chkReady),
    .wr_conflict_o  (wrConflict)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one value and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Return all request inputs to idle.
  task automatic clearInputs();
    wrEn       = '0;
    wrPreg     = '0;
    wrArchZero = '0;
    wrData     = '0;
    rdEn       = '0;
    rdPreg     = '0;
    allocEn    = 1'b0;
    allocPreg  = '0;
    flush      = 1'b0;
    chkPreg    = '0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one table vector for a single cycle, then check the read result.
  task automatic applyStimulus(input vec_t v, input int idx);
    clearInputs();
    if (v.wrOn) begin
      wrEn[v.wrPort]       = 1'b1;
      wrPreg[v.wrPort]     = v.wrReg;
      wrData[v.wrPort]     = v.wrVal;
      wrArchZero[v.wrPort] = v.archZero;
    end
    rdEn[v.rdPort]   = 1'b1;
    rdPreg[v.rdPort] = v.rdReg;
    step();
    clearInputs();
    checkOutput($sformatf("vec%0d rd_data[%0d]", idx, v.rdPort), rdData[v.rdPort], v.expData);
    checkOutput($sformatf("vec%0d wr_conflict", idx), {31'd0, wrConflict}, 32'd0);
  endtask

  // Query every register through the check ports; all must be ready.
  task automatic checkAllReady(input string tag);
    for (int g = 0; g < 64; g += NCK) begin
      for (int k = 0; k < NCK; k++) chkPreg[k] = 6'(g + k);
      #1;
      for (int k = 0; k < NCK; k++)
        checkOutput($sformatf("%s chk p%0d", tag, g + k), {31'd0, chkReady[k]}, 32'd1);
    end
    chkPreg = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 0, 6'd5,  32'hDEADBEEF, 1'b0, 3, 6'd5,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 0, 6'd0,  32'h0,        1'b0, 3, 6'd5,  32'hDEADBEEF};
    vecs[2] = '{1'b1, 2, 6'd7,  32'h12345678, 1'b1, 1, 6'd7,  32'h0};
    vecs[3] = '{1'b0, 0, 6'd0,  32'h0,        1'b0, 1, 6'd7,  32'h0};
    vecs[4] = '{1'b1, 4, 6'd0,  32'hFFFFFFFF, 1'b0, 0, 6'd0,  32'h0};
    vecs[5] = '{1'b0, 0, 6'd0,  32'h0,        1'b0, 0, 6'd0,  32'h0};
    vecs[6] = '{1'b1, 1, 6'd30, 32'hCAFEF00D, 1'b0, 9, 6'd5,  32'hDEADBEEF};
    vecs[7] = '{1'b0, 0, 6'd0,  32'h0,        1'b0, 9, 6'd30, 32'hCAFEF00D};
    vecs[8] = '{1'b1, 3, 6'd63, 32'hA5A5A5A5, 1'b0, 5, 6'd62, 32'h0};
    vecs[9] = '{1'b0, 0, 6'd0,  32'h0,        1'b0, 5, 6'd63, 32'hA5A5A5A5};

    clearInputs();
    rstN = 1'b0;
    step();
    step();
    rstN = 1'b1;

    // Reset state: every register reads zero and is ready.
    for (int p = 0; p < 64; p++) begin
      rdEn[p % NRD]   = 1'b1;
      rdPreg[p % NRD] = 6'(p);
      step();
      clearInputs();
      checkOutput($sformatf("reset read p%0d", p), rdData[p % NRD], 32'h0);
    end
    checkAllReady("reset");
    checkOutput("reset wr_conflict", {31'd0, wrConflict}, 32'd0);

    // Table-driven write/read vectors.
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    // rd_en low holds the previous value even if the index changes.
    rdPreg[5] = 6'd5;
    step();
    checkOutput("hold rd_data[5]", rdData[5], 32'hA5A5A5A5);
    clearInputs();

    // Allocation: ready unaffected in the same cycle, cleared afterwards.
    allocEn = 1'b1; allocPreg = 6'd9; chkPreg[0] = 6'd9;
    #1;
    checkOutput("alloc same-cycle chk p9", {31'd0, chkReady[0]}, 32'd1);
    step();
    allocEn = 1'b0;
    #1;
    checkOutput("after alloc chk p9", {31'd0, chkReady[0]}, 32'd0);
    // Writeback wakes p9 combinationally.
    wrEn[2] = 1'b1; wrPreg[2] = 6'd9; wrData[2] = 32'h99;
    #1;
    checkOutput("wakeup bypass chk p9", {31'd0, chkReady[0]}, 32'd1);
    step();
    wrEn = '0;
    #1;
    checkOutput("after write chk p9", {31'd0, chkReady[0]}, 32'd1);
    // Re-allocate then flush.
    allocEn = 1'b1; allocPreg = 6'd9;
    step();
    allocEn = 1'b0;
    #1;
    checkOutput("realloc chk p9", {31'd0, chkReady[0]}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    checkOutput("flush chk p9", {31'd0, chkReady[0]}, 32'd1);
    // Flush beats a same-cycle alloc.
    allocEn = 1'b1; allocPreg = 6'd9; flush = 1'b1;
    step();
    clearInputs();
    chkPreg[0] = 6'd9;
    #1;
    checkOutput("flush+alloc chk p9", {31'd0, chkReady[0]}, 32'd1);
    checkOutput("no conflict yet", {31'd0, wrConflict}, 32'd0);

    // p0 allocation is ignored.
    allocEn = 1'b1; allocPreg = 6'd0;
    step();
    clearInputs();
    #1;
    checkOutput("alloc p0 chk", {31'd0, chkReady[0]}, 32'd1);

    // Two writers to p12: lowest port wins, conflict becomes sticky.
    wrEn[1] = 1'b1; wrPreg[1] = 6'd12; wrData[1] = 32'h11;
    wrEn[4] = 1'b1; wrPreg[4] = 6'd12; wrData[4] = 32'h44;
    rdEn[0] = 1'b1; rdPreg[0] = 6'd12;
    step();
    clearInputs();
    checkOutput("conflict bypass p12", rdData[0], 32'h11);
    checkOutput("conflict flag set", {31'd0, wrConflict}, 32'd1);
    rdEn[2] = 1'b1; rdPreg[2] = 6'd12;
    step();
    clearInputs();
    checkOutput("conflict array p12", rdData[2], 32'h11);
    step();
    step();
    checkOutput("conflict flag sticky", {31'd0, wrConflict}, 32'd1);

    // Alloc and write to the same register: alloc wins, data still lands.
    allocEn = 1'b1; allocPreg = 6'd15;
    wrEn[0] = 1'b1; wrPreg[0] = 6'd15; wrData[0] = 32'h55;
    step();
    clearInputs();
    chkPreg[1] = 6'd15;
    rdEn[4] = 1'b1; rdPreg[4] = 6'd15;
    #1;
    checkOutput("alloc+write chk p15", {31'd0, chkReady[1]}, 32'd0);
    step();
    clearInputs();
    checkOutput("alloc+write data p15", rdData[4], 32'h55);

    // Asynchronous reset mid-cycle after writing p20.
    wrEn[3] = 1'b1; wrPreg[3] = 6'd20; wrData[3] = 32'h00002020;
    rdEn[6] = 1'b1; rdPreg[6] = 6'd20;
    step();
    clearInputs();
    checkOutput("p20 before reset", rdData[6], 32'h00002020);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async reset rd_data[6]", rdData[6], 32'h0);
    checkOutput("async reset wr_conflict", {31'd0, wrConflict}, 32'd0);
    step();
    rstN = 1'b1;
    rdEn[6] = 1'b1; rdPreg[6] = 6'd20;
    step();
    clearInputs();
    checkOutput("p20 after reset", rdData[6], 32'h0);
    checkAllReady("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
